// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Issues aligned data-memory requests,
// stalls the upstream pipeline across the dmem handshake and registers
// the MEM/WB result (load data or pass-through ALU result).
module mem_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic [WIDTH-1:0] rs2_out_i,
  input  logic [4:0]       rd_i,
  input  logic             load_regfile_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [2:0]       funct3_i,
  output logic [WIDTH-1:0] dmem_address,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [3:0]       dmem_mbe,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic             stall_o,
  output logic             wb_valid_o,
  output logic             wb_load_o,
  output logic [4:0]       wb_rd_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             misalign_o
);

  localparam int unsigned OFF_W = 2;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned F3_W  = 3;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_dmem_address, w_dmem_address_nxt;
  logic               r_dmem_read, w_dmem_read_nxt;
  logic               r_dmem_write, w_dmem_write_nxt;
  logic [3:0]         r_dmem_mbe, w_dmem_mbe_nxt;
  logic [WIDTH-1:0]   r_dmem_wdata, w_dmem_wdata_nxt;
  logic [RD_W-1:0]    r_rd, w_rd_nxt;
  logic [F3_W-1:0]    r_funct3, w_funct3_nxt;
  logic [OFF_W-1:0]   r_off, w_off_nxt;
  logic               r_flushed, w_flushed_nxt;
  logic               r_wb_valid, w_wb_valid_nxt;
  logic               r_wb_load, w_wb_load_nxt;
  logic [RD_W-1:0]    r_wb_rd, w_wb_rd_nxt;
  logic [WIDTH-1:0]   r_wb_data, w_wb_data_nxt;
  logic               r_misalign, w_misalign_nxt;

  logic [OFF_W-1:0]   w_off;
  logic               w_misaligned;
  logic [3:0]         w_mbe;
  logic [WIDTH-1:0]   w_wdata;
  logic [WIDTH-1:0]   w_lane;
  logic [WIDTH-1:0]   w_load_data;
  logic               w_kill;

  assign w_off = alu_out_i[OFF_W-1:0];

  // Access-size decode of the incoming instruction: alignment, byte enables, store lanes
  always_comb begin
    w_misaligned = 1'b0;
    w_mbe        = 4'b1111;
    w_wdata      = rs2_out_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_mbe   = 4'(4'b0001 << w_off);
        w_wdata = {4{rs2_out_i[7:0]}};
      end
      2'b01: begin
        w_misaligned = w_off[0];
        w_mbe        = 4'(4'b0011 << w_off);
        w_wdata      = {2{rs2_out_i[15:0]}};
      end
      default: begin
        w_misaligned = (w_off != 2'b00);
      end
    endcase
  end

  // Load extraction from the returned word using the latched offset and size
  always_comb begin
    w_lane = dmem_rdata >> {r_off, 3'b000};
    case (r_funct3)
      3'b000:  w_load_data = {{(WIDTH-8){w_lane[7]}}, w_lane[7:0]};
      3'b100:  w_load_data = {{(WIDTH-8){1'b0}}, w_lane[7:0]};
      3'b001:  w_load_data = {{(WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      3'b101:  w_load_data = {{(WIDTH-16){1'b0}}, w_lane[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // A flush seen at any point of the access kills its write-back
  assign w_kill = r_flushed | flush_i;

  // Next-state and next-register values; stall_o is the only combinational output
  always_comb begin
    w_state_nxt        = r_state;
    w_dmem_address_nxt = r_dmem_address;
    w_dmem_read_nxt    = r_dmem_read;
    w_dmem_write_nxt   = r_dmem_write;
    w_dmem_mbe_nxt     = r_dmem_mbe;
    w_dmem_wdata_nxt   = r_dmem_wdata;
    w_rd_nxt           = r_rd;
    w_funct3_nxt       = r_funct3;
    w_off_nxt          = r_off;
    w_flushed_nxt      = r_flushed;
    w_wb_valid_nxt     = 1'b0;
    w_wb_load_nxt      = 1'b0;
    w_wb_rd_nxt        = r_wb_rd;
    w_wb_data_nxt      = r_wb_data;
    w_misalign_nxt     = 1'b0;
    stall_o            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (valid_i && !flush_i) begin
          if (mem_read_i || mem_write_i) begin
            if (w_misaligned) begin
              w_wb_valid_nxt = 1'b1;
              w_wb_rd_nxt    = rd_i;
              w_wb_data_nxt  = alu_out_i;
              w_misalign_nxt = 1'b1;
            end else begin
              stall_o            = 1'b1;
              w_state_nxt        = S_ACCESS;
              w_dmem_address_nxt = {alu_out_i[WIDTH-1:OFF_W], 2'b00};
              w_dmem_read_nxt    = mem_read_i;
              w_dmem_write_nxt   = mem_write_i;
              w_dmem_mbe_nxt     = w_mbe;
              w_dmem_wdata_nxt   = w_wdata;
              w_rd_nxt           = rd_i;
              w_funct3_nxt       = funct3_i;
              w_off_nxt          = w_off;
              w_flushed_nxt      = 1'b0;
            end
          end else begin
            w_wb_valid_nxt = 1'b1;
            w_wb_load_nxt  = load_regfile_i;
            w_wb_rd_nxt    = rd_i;
            w_wb_data_nxt  = alu_out_i;
          end
        end
      end
      S_ACCESS: begin
        if (flush_i) begin
          w_flushed_nxt = 1'b1;
        end
        if (dmem_resp) begin
          w_state_nxt      = S_IDLE;
          w_dmem_read_nxt  = 1'b0;
          w_dmem_write_nxt = 1'b0;
          w_wb_valid_nxt   = !w_kill;
          w_wb_load_nxt    = r_dmem_read && !w_kill;
          w_wb_rd_nxt      = r_rd;
          w_wb_data_nxt    = r_dmem_read ? w_load_data : '0;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_dmem_address <= '0;
      r_dmem_read    <= 1'b0;
      r_dmem_write   <= 1'b0;
      r_dmem_mbe     <= '0;
      r_dmem_wdata   <= '0;
      r_rd           <= '0;
      r_funct3       <= '0;
      r_off          <= '0;
      r_flushed      <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_load      <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_data      <= '0;
      r_misalign     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_dmem_address <= w_dmem_address_nxt;
      r_dmem_read    <= w_dmem_read_nxt;
      r_dmem_write   <= w_dmem_write_nxt;
      r_dmem_mbe     <= w_dmem_mbe_nxt;
      r_dmem_wdata   <= w_dmem_wdata_nxt;
      r_rd           <= w_rd_nxt;
      r_funct3       <= w_funct3_nxt;
      r_off          <= w_off_nxt;
      r_flushed      <= w_flushed_nxt;
      r_wb_valid     <= w_wb_valid_nxt;
      r_wb_load      <= w_wb_load_nxt;
      r_wb_rd        <= w_wb_rd_nxt;
      r_wb_data      <= w_wb_data_nxt;
      r_misalign     <= w_misalign_nxt;
    end
  end

  assign dmem_address = r_dmem_address;
  assign dmem_read    = r_dmem_read;
  assign dmem_write   = r_dmem_write;
  assign dmem_mbe     = r_dmem_mbe;
  assign dmem_wdata   = r_dmem_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign wb_load_o    = r_wb_load;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign misalign_o   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for single-cycle slots plus hand-written
// dmem handshake sequences for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, flush_i, load_regfile_i, mem_read_i, mem_write_i;
  logic [31:0] alu_out_i, rs2_out_i, dmem_rdata;
  logic [4:0]  rd_i;
  logic [2:0]  funct3_i;
  logic        dmem_resp;
  logic [31:0] dmem_address, dmem_wdata, wb_data_o;
  logic        dmem_read, dmem_write, stall_o, wb_valid_o, wb_load_o, misalign_o;
  logic [3:0]  dmem_mbe;
  logic [4:0]  wb_rd_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .alu_out_i(alu_out_i), .rs2_out_i(rs2_out_i), .rd_i(rd_i),
    .load_regfile_i(load_regfile_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_mbe(dmem_mbe), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall_o(stall_o), .wb_valid_o(wb_valid_o),
    .wb_load_o(wb_load_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        valid, flush, ldrf, mr, mw;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        e_wbv, e_wbl, e_mis, chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[8];

  task automatic idle_inputs();
    valid_i = 1'b0; flush_i = 1'b0; load_regfile_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; alu_out_i = '0; rs2_out_i = '0;
    rd_i = '0; funct3_i = '0; dmem_resp = 1'b0; dmem_rdata = '0;
  endtask

  // One single-cycle slot; called and returns at posedge+1
  task automatic apply_vec(input vec_t v);
    valid_i = v.valid; flush_i = v.flush; load_regfile_i = v.ldrf;
    mem_read_i = v.mr; mem_write_i = v.mw; alu_out_i = v.alu;
    rd_i = v.rd; funct3_i = v.f3; rs2_out_i = 32'h1111_2222;
    @(negedge clk);
    chk({v.nm, ".stall"}, 32'(stall_o), 0);
    @(posedge clk); #1;
    chk({v.nm, ".dmem_req"}, 32'({dmem_read, dmem_write}), 0);
    chk({v.nm, ".wb_valid"}, 32'(wb_valid_o), 32'(v.e_wbv));
    chk({v.nm, ".wb_load"}, 32'(wb_load_o), 32'(v.e_wbl));
    chk({v.nm, ".misalign"}, 32'(misalign_o), 32'(v.e_mis));
    if (v.e_wbv) chk({v.nm, ".wb_rd"}, 32'(wb_rd_o), 32'(v.rd));
    if (v.chk_data) chk({v.nm, ".wb_data"}, wb_data_o, v.e_data);
    idle_inputs();
  endtask

  // Full aligned access: accept cycle, 'waits' ACCESS cycles without resp, then resp
  task automatic mem_op(input string nm, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic mw,
                        input logic [2:0] f3, input int waits, input int flush_at,
                        input logic [31:0] rdata, input logic [3:0] e_mbe,
                        input logic [31:0] e_wdata, input logic e_wbv,
                        input logic e_wbl, input logic [31:0] e_data);
    int stalls = 0;
    logic [31:0] e_addr = {addr[31:2], 2'b00};
    valid_i = 1'b1; flush_i = 1'b0; load_regfile_i = mr; mem_read_i = mr;
    mem_write_i = mw; alu_out_i = addr; rs2_out_i = rs2; rd_i = rd; funct3_i = f3;
    @(negedge clk);
    if (stall_o) stalls++;
    chk({nm, ".no_req_yet"}, 32'({dmem_read, dmem_write}), 0);
    @(posedge clk); #1;
    chk({nm, ".addr"}, dmem_address, e_addr);
    chk({nm, ".rw"}, 32'({dmem_read, dmem_write}), 32'({mr, mw}));
    chk({nm, ".mbe"}, 32'(dmem_mbe), 32'(e_mbe));
    if (mw) chk({nm, ".wdata"}, dmem_wdata, e_wdata);
    chk({nm, ".wb_bubble"}, 32'(wb_valid_o), 0);
    for (int i = 0; i < waits; i++) begin
      flush_i = (i == flush_at);
      @(negedge clk);
      if (stall_o) stalls++;
      chk({nm, ".hold"}, {dmem_address[31:6], dmem_mbe, dmem_read, dmem_write},
          {e_addr[31:6], e_mbe, mr, mw});
      @(posedge clk); #1;
    end
    flush_i = 1'b0; dmem_resp = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    chk({nm, ".stall_resp"}, 32'(stall_o), 0);
    chk({nm, ".stall_cycles"}, 32'(stalls), 32'(waits + 1));
    @(posedge clk); #1;
    idle_inputs();
    chk({nm, ".req_drop"}, 32'({dmem_read, dmem_write}), 0);
    chk({nm, ".wb_valid"}, 32'(wb_valid_o), 32'(e_wbv));
    chk({nm, ".wb_load"}, 32'(wb_load_o), 32'(e_wbl));
    if (e_wbv) begin
      chk({nm, ".wb_rd"}, 32'(wb_rd_o), 32'(rd));
      chk({nm, ".wb_data"}, wb_data_o, e_data);
    end
  endtask

  initial begin
    //          nm        val flu ldrf mr  mw  alu           rd     f3      wbv  wbl  mis  chkd data
    vecs[0] = '{"add",    1,  0,  1,   0,  0,  32'h55,       5'd3,  3'b000, 1,   1,   0,   1,   32'h55};
    vecs[1] = '{"bubble", 0,  0,  1,   0,  0,  32'h77,       5'd4,  3'b000, 0,   0,   0,   0,   32'h0};
    vecs[2] = '{"fl_add", 1,  1,  1,   0,  0,  32'h99,       5'd5,  3'b000, 0,   0,   0,   0,   32'h0};
    vecs[3] = '{"lw_mis", 1,  0,  1,   1,  0,  32'h101,      5'd6,  3'b010, 1,   0,   1,   0,   32'h0};
    vecs[4] = '{"lh_mis", 1,  0,  1,   1,  0,  32'h103,      5'd7,  3'b001, 1,   0,   1,   0,   32'h0};
    vecs[5] = '{"sw_mis", 1,  0,  0,   0,  1,  32'h102,      5'd0,  3'b010, 1,   0,   1,   0,   32'h0};
    vecs[6] = '{"fl_lw",  1,  1,  1,   1,  0,  32'h100,      5'd8,  3'b010, 0,   0,   0,   0,   32'h0};
    vecs[7] = '{"nold",   1,  0,  0,   0,  0,  32'hCAFE,     5'd9,  3'b000, 1,   0,   0,   1,   32'hCAFE};

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("rst.dmem", {dmem_address[31:8], dmem_mbe, 2'b00, dmem_read, dmem_write}, 0);
    chk("rst.wdata", dmem_wdata, 0);
    chk("rst.wb", {wb_data_o[31:8], wb_rd_o, wb_valid_o, wb_load_o, misalign_o}, 0);
    chk("rst.stall", 32'(stall_o), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    mem_op("lw",    32'h100, 32'h0,        5'd10, 1, 0, 3'b010, 3, -1, 32'hDEADBEEF, 4'b1111, 32'h0,        1, 1, 32'hDEADBEEF);
    mem_op("lb",    32'h103, 32'h0,        5'd11, 1, 0, 3'b000, 0, -1, 32'h80FFFFFF, 4'b1000, 32'h0,        1, 1, 32'hFFFFFF80);
    mem_op("lbu",   32'h103, 32'h0,        5'd12, 1, 0, 3'b100, 1, -1, 32'h80FFFFFF, 4'b1000, 32'h0,        1, 1, 32'h00000080);
    mem_op("sh",    32'h102, 32'h1234ABCD, 5'd0,  0, 1, 3'b001, 1, -1, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 1, 0, 32'h0);
    mem_op("sb",    32'h101, 32'h000000EF, 5'd0,  0, 1, 3'b000, 0, -1, 32'h0,        4'b0010, 32'hEFEFEFEF, 1, 0, 32'h0);
    mem_op("lh",    32'h102, 32'h0,        5'd13, 1, 0, 3'b001, 2, -1, 32'h80010000, 4'b1100, 32'h0,        1, 1, 32'hFFFF8001);
    mem_op("lhu",   32'h000, 32'h0,        5'd14, 1, 0, 3'b101, 0, -1, 32'h1234F00D, 4'b0011, 32'h0,        1, 1, 32'h0000F00D);
    mem_op("sw",    32'h200, 32'hCAFEBABE, 5'd0,  0, 1, 3'b010, 2, -1, 32'h0,        4'b1111, 32'hCAFEBABE, 1, 0, 32'h0);
    mem_op("lw_fl", 32'h104, 32'h0,        5'd15, 1, 0, 3'b010, 2, 1,  32'h12345678, 4'b1111, 32'h0,        0, 0, 32'h0);

    // add immediately followed by lw: add reaches WB without stalling
    valid_i = 1'b1; load_regfile_i = 1'b1; alu_out_i = 32'h55; rd_i = 5'd1;
    @(negedge clk);
    chk("b2b.add_stall", 32'(stall_o), 0);
    @(posedge clk); #1;
    chk("b2b.add_wb", {wb_data_o[27:0], wb_rd_o, wb_valid_o, wb_load_o},
        {28'h55, 5'd1, 2'b11});
    mem_op("b2b_lw", 32'h300, 32'h0, 5'd2, 1, 0, 3'b010, 1, -1, 32'hA5A5_5A5A,
           4'b1111, 32'h0, 1, 1, 32'hA5A5_5A5A);

    // async reset in the middle of an access, then a stray resp in IDLE
    valid_i = 1'b1; mem_read_i = 1'b1; load_regfile_i = 1'b1;
    alu_out_i = 32'h400; rd_i = 5'd20; funct3_i = 3'b010;
    @(posedge clk); #1;
    chk("rstmid.req", 32'(dmem_read), 1);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.read_drop", 32'({dmem_read, dmem_write}), 0);
    chk("rstmid.wb_valid", 32'(wb_valid_o), 0);
    chk("rstmid.stall", 32'(stall_o), 0);
    #2 rst_n = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("stray_resp.wb_valid", 32'(wb_valid_o), 0);
    chk("stray_resp.wb_data", wb_data_o, 0);
    chk("stray_resp.req", 32'({dmem_read, dmem_write}), 0);

    // stage still works after the reset
    apply_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
